ts4231_emulator: RTL and testbench



---
 rtl/ts4231_emu_pkg.sv | 39 +++
 rtl/ts4231_sync_edge.sv | 39 +++
 rtl/ts4231_emulator.sv | 239 +++++++++++++++++++++++
 tb/tb_ts4231_emulator.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts4231_emu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ts4231_emu_pkg
//  Description : Shared types and constants for the TS4231 pin-level emulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package ts4231_emu_pkg;

  // Width of the configuration word shifted in by the initiator
  localparam int CFG_BITS = 16;

  // Configuration word the initiator is expected to send
  localparam logic [CFG_BITS-1:0] DEFAULT_EXPECTED_CONFIG = 16'h7256;

  // Width of every cycle counter (delay, length, timeout, hint)
  localparam int CNT_W = 16;

  typedef enum logic [3:0] {
    ST_SLEEP       = 4'd0,
    ST_CFG_IDLE    = 4'd1,
    ST_CFG_SHIFT   = 4'd2,
    ST_CFG_STOP    = 4'd3,
    ST_WATCH_E_LOW = 4'd4,
    ST_WATCH_D_LOW = 4'd5,
    ST_RELEASE     = 4'd6,
    ST_IDLE        = 4'd7,
    ST_ENV_DELAY   = 4'd8,
    ST_ENV         = 4'd9
  } emu_state_t;

  // States in which the bus-edge watchdog is armed
  function automatic logic is_cfg_state(input emu_state_t s);
    return (s == ST_CFG_IDLE)    || (s == ST_CFG_SHIFT)   ||
           (s == ST_CFG_STOP)    || (s == ST_WATCH_E_LOW) ||
           (s == ST_WATCH_D_LOW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ts4231_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : ts4231_sync_edge
//  Description : Two-flop synchronizer for one pad plus rise/fall pulses.
//                All flops reset high so an idle-high bus shows no edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module ts4231_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Metastability chain followed by a history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign level = r_sync;
  assign rise  = r_sync & ~r_prev;
  assign fall  = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/ts4231_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : ts4231_emulator
//  Description : Pin-level TS4231 model: configuration responder on E/D and
//                source of light envelopes. Split in/out/oe pad signals.
//                Optional macro TS4231_EMU_HINT_EN compiles the D hint
//                generator that runs while unconfigured.
//  Revision    : 1.0 - initial release
// ============================================================================
module ts4231_emulator
  import ts4231_emu_pkg::*;
#(
  parameter int                  HINT_PERIOD     = 1200,
  parameter int                  HINT_WIDTH      = 24,
  parameter logic [CFG_BITS-1:0] EXPECTED_CONFIG = DEFAULT_EXPECTED_CONFIG,
  parameter int                  EDGE_TIMEOUT    = 4096,
  parameter int                  RELEASE_DELAY   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                e_in,
  input  logic                d_in,
  output logic                e_out,
  output logic                e_oe,
  output logic                d_out,
  output logic                d_oe,
  input  logic                pulse_valid,
  output logic                pulse_ready,
  input  logic [CNT_W-1:0]    pulse_delay,
  input  logic [CNT_W-1:0]    pulse_length,
  input  logic                pulse_data,
  output logic                configured,
  output logic                config_error,
  output logic [CFG_BITS-1:0] config_word
);

  localparam logic [4:0]       c_bits_full = 5'(CFG_BITS);
  localparam logic [4:0]       c_bit_sat   = 5'd31;
  localparam logic [CNT_W-1:0] c_to_last   = CNT_W'(EDGE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_rel_last  = CNT_W'(RELEASE_DELAY - 1);

  logic w_e_lvl, w_e_rise, w_e_fall;
  logic w_d_lvl, w_d_rise, w_d_fall;

  emu_state_t r_state, w_state_next;

  logic [1:0]          r_settle;
  logic                w_settled;
  logic [4:0]          r_bit_cnt;
  logic [CFG_BITS-1:0] r_shift;
  logic [CNT_W-1:0]    r_to_cnt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_delay_m1;
  logic [CNT_W-1:0]    r_len_m1;
  logic                r_data;
  logic                r_configured;
  logic                r_error;
  logic [CFG_BITS-1:0] r_word;

  logic w_any_edge, w_start, w_shift, w_stop, w_timeout, w_accept;

  ts4231_sync_edge u_sync_e (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (e_in),
    .level    (w_e_lvl),
    .rise     (w_e_rise),
    .fall     (w_e_fall)
  );

  ts4231_sync_edge u_sync_d (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (d_in),
    .level    (w_d_lvl),
    .rise     (w_d_rise),
    .fall     (w_d_fall)
  );

  assign w_settled = (r_settle == 2'd2);

  // Hold SLEEP until the synchronizers have flushed their reset-high value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_settle <= 2'd0;
    else if (!w_settled) r_settle <= r_settle + 2'd1;
  end

`ifdef TS4231_EMU_HINT_EN
  logic [CNT_W-1:0] r_hint_cnt;

  // Free-running hint phase counter, restarted whenever SLEEP is left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_hint_cnt <= '0;
    else if (r_state != ST_SLEEP)                r_hint_cnt <= '0;
    else if (r_hint_cnt == CNT_W'(HINT_PERIOD - 1)) r_hint_cnt <= '0;
    else                                         r_hint_cnt <= r_hint_cnt + 1'b1;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_SLEEP;
    else        r_state <= w_state_next;
  end

  // Next-state, protocol strobes and pad drive
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_shift      = 1'b0;
    w_stop       = 1'b0;
    w_accept     = 1'b0;
    e_out        = 1'b1;
    d_out        = 1'b1;
    e_oe         = 1'b0;
    d_oe         = 1'b0;
    pulse_ready  = 1'b0;
    w_any_edge   = w_e_rise | w_e_fall | w_d_rise | w_d_fall;
    w_timeout    = is_cfg_state(r_state) && !w_any_edge && (r_to_cnt == c_to_last);

    case (r_state)
      ST_SLEEP: begin
`ifdef TS4231_EMU_HINT_EN
        // Hint drive is dropped combinationally as soon as E reads high
        d_oe  = ~w_e_lvl;
        d_out = (r_hint_cnt < CNT_W'(HINT_WIDTH));
`endif
        if (w_settled && w_e_lvl) w_state_next = ST_CFG_IDLE;
      end
      ST_CFG_IDLE: begin
        if (w_d_fall && w_e_lvl) begin
          w_start      = 1'b1;
          w_state_next = ST_CFG_SHIFT;
        end
      end
      ST_CFG_SHIFT: begin
        if (w_d_rise && w_e_lvl) begin
          w_stop       = 1'b1;
          w_state_next = (r_bit_cnt == c_bits_full) ? ST_CFG_STOP : ST_SLEEP;
        end else if (w_e_rise) begin
          w_shift = 1'b1;
        end
      end
      ST_CFG_STOP:    if (w_e_fall) w_state_next = ST_WATCH_E_LOW;
      ST_WATCH_E_LOW: if (w_d_fall) w_state_next = ST_WATCH_D_LOW;
      ST_WATCH_D_LOW: if (w_e_rise) w_state_next = ST_RELEASE;
      ST_RELEASE:     if (r_cnt == c_rel_last) w_state_next = ST_IDLE;
      ST_IDLE: begin
        e_oe        = 1'b1;
        d_oe        = 1'b1;
        pulse_ready = 1'b1;
        if (pulse_valid) begin
          w_accept     = 1'b1;
          w_state_next = (pulse_delay == '0) ? ST_ENV : ST_ENV_DELAY;
        end
      end
      ST_ENV_DELAY: begin
        e_oe = 1'b1;
        d_oe = 1'b1;
        if (r_cnt == r_delay_m1) w_state_next = ST_ENV;
      end
      ST_ENV: begin
        e_oe  = 1'b1;
        d_oe  = 1'b1;
        e_out = 1'b0;
        d_out = r_data;
        if (r_cnt == r_len_m1) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_SLEEP;
    endcase

    if (w_timeout) w_state_next = ST_SLEEP;
  end

  // Cycles spent in the current timed state (release, delay, envelope)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (w_state_next != r_state) r_cnt <= '0;
    else if (r_state == ST_RELEASE || r_state == ST_ENV_DELAY || r_state == ST_ENV)
                                      r_cnt <= r_cnt + 1'b1;
    else                              r_cnt <= '0;
  end

  // Cycles since the last bus edge while configuration is in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_to_cnt <= '0;
    else if (!is_cfg_state(r_state) || w_any_edge) r_to_cnt <= '0;
    else                                         r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Command fields captured at acceptance; later input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_delay_m1 <= '0;
      r_len_m1   <= '0;
      r_data     <= 1'b0;
    end else if (w_accept) begin
      r_delay_m1 <= pulse_delay - 1'b1;
      r_len_m1   <= (pulse_length == '0) ? '0 : pulse_length - 1'b1;
      r_data     <= pulse_data;
    end
  end

  // MSB-first shift register and saturating bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_start) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_shift) begin
      r_shift <= {r_shift[CFG_BITS-2:0], w_d_lvl};
      if (r_bit_cnt != c_bit_sat) r_bit_cnt <= r_bit_cnt + 5'd1;
    end
  end

  // Sticky status: captured word, error flag and configured flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word       <= '0;
      r_error      <= 1'b0;
      r_configured <= 1'b0;
    end else begin
      if (w_stop && r_bit_cnt == c_bits_full) begin
        r_word <= r_shift;
        if (r_shift != EXPECTED_CONFIG) r_error <= 1'b1;
      end
      if ((w_stop && r_bit_cnt != c_bits_full) || w_timeout) r_error <= 1'b1;
      if (r_state == ST_RELEASE && w_state_next == ST_IDLE) r_configured <= 1'b1;
    end
  end

  assign configured   = r_configured;
  assign config_error = r_error;
  assign config_word  = r_word;

endmodule
`default_nettype wire

// File: tb/tb_ts4231_emulator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ts4231_emulator
//  Description : Self-checking bench for ts4231_emulator. A pad model resolves
//                emulator and initiator drive; envelopes are scoreboarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ts4231_emulator;

  localparam int HINT_PERIOD   = 1200;
  localparam int HINT_WIDTH    = 24;
  localparam int EDGE_TIMEOUT  = 4096;
  localparam int RELEASE_DELAY = 32;
  localparam int SYNC_LAT      = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tb_e = 1'b0, tb_d = 1'b1, tb_e_oe = 1'b1, tb_d_oe = 1'b1;
  logic        e_out, e_oe, d_out, d_oe;
  logic        pulse_valid = 1'b0, pulse_ready, pulse_data = 1'b0;
  logic [15:0] pulse_delay = '0, pulse_length = '0;
  logic        configured, config_error;
  logic [15:0] config_word;
  logic        e_pad, d_pad;

  // Pads: emulator drive wins, then the initiator, otherwise pulled low
  assign e_pad = e_oe ? e_out : (tb_e_oe ? tb_e : 1'b0);
  assign d_pad = d_oe ? d_out : (tb_d_oe ? tb_d : 1'b0);

  ts4231_emulator #(
    .HINT_PERIOD     (HINT_PERIOD),
    .HINT_WIDTH      (HINT_WIDTH),
    .EXPECTED_CONFIG (16'h7256),
    .EDGE_TIMEOUT    (EDGE_TIMEOUT),
    .RELEASE_DELAY   (RELEASE_DELAY)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .e_in         (e_pad),
    .d_in         (d_pad),
    .e_out        (e_out),
    .e_oe         (e_oe),
    .d_out        (d_out),
    .d_oe         (d_oe),
    .pulse_valid  (pulse_valid),
    .pulse_ready  (pulse_ready),
    .pulse_delay  (pulse_delay),
    .pulse_length (pulse_length),
    .pulse_data   (pulse_data),
    .configured   (configured),
    .config_error (config_error),
    .config_word  (config_word)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- envelope scoreboard ----------------
  typedef struct {
    int   start_c;
    int   end_c;
    logic data;
  } env_exp_t;

  env_exp_t sb_q[$];
  env_exp_t mon_exp;
  logic     mon_in_env = 1'b0;
  int       mon_start;
  logic     mon_data, mon_data_bad, mon_ready_bad;

  // Envelope monitor: measures each E-low window on the pads
  always @(negedge clk) begin
    if (!mon_in_env) begin
      if (e_oe && !e_out) begin
        mon_in_env    = 1'b1;
        mon_start     = cyc;
        mon_data      = d_pad;
        mon_data_bad  = 1'b0;
        mon_ready_bad = pulse_ready;
      end
    end else if (!e_oe) begin
      mon_in_env = 1'b0;
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else if (!e_pad) begin
      if (d_pad !== mon_data) mon_data_bad = 1'b1;
      if (pulse_ready) mon_ready_bad = 1'b1;
    end else begin
      mon_in_env = 1'b0;
      check("env_expected", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        mon_exp = sb_q.pop_front();
        check("env_start", mon_start, mon_exp.start_c);
        check("env_end", cyc - 1, mon_exp.end_c);
        check("env_data", mon_data, mon_exp.data);
        check("env_data_stable", mon_data_bad, 0);
        check("env_ready_low", mon_ready_bad, 0);
        check("env_ready_back", pulse_ready, 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pulse_valid = 1'b0;
    tb_e_oe = 1'b1; tb_d_oe = 1'b1; tb_e = 1'b0; tb_d = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  // Initiator side of the configuration protocol; sends word[nbits-1:0]
  task automatic send_config(input logic [15:0] word, input int nbits,
                             input bit do_stop, output int t_rise);
    logic prev;
    tb_e_oe = 1'b1; tb_d_oe = 1'b1;
    tb_e = 1'b0; tb_d = 1'b1;
    tick(6);
`ifdef TS4231_EMU_HINT_EN
    // Raise E in the quiet part of the hint so release is glitch free
    if (d_oe) begin
      for (int i = 0; i < HINT_PERIOD + 50; i++) begin
        prev = d_out;
        @(negedge clk);
        if (prev && !d_out) break;
      end
      tick(3);
    end
`endif
    tb_e = 1'b1; tick(6);
    tb_d = 1'b0; tick(6);
    for (int i = nbits - 1; i >= 0; i--) begin
      tb_e = 1'b0; tick(4);
      tb_d = word[i]; tick(4);
      tb_e = 1'b1; tick(4);
    end
    t_rise = cyc;
    if (!do_stop) return;
    if (tb_d) begin tb_d = 1'b0; tick(4); end
    tb_d = 1'b1; tick(4);
    tb_e = 1'b0; tick(4);
    tb_d = 1'b0; tick(4);
    tb_e = 1'b1;
    t_rise = cyc;
  endtask

  // Pad change lands on the next edge, crosses two flops, then RELEASE_DELAY
  task automatic check_release(input int t_rise, input logic [15:0] exp_word, input logic exp_err);
    int t_idle;
    t_idle = t_rise + 1 + SYNC_LAT + RELEASE_DELAY;
    tick(10);
    tb_e_oe = 1'b0; tb_d_oe = 1'b0;
    while (cyc < t_idle - 1) @(negedge clk);
    check("ready_before_release", pulse_ready, 0);
    check("cfg_before_release", configured, 0);
    @(negedge clk);
    check("ready_after_release", pulse_ready, 1);
    check("configured", configured, 1);
    check("config_word", config_word, exp_word);
    check("config_error", config_error, exp_err);
  endtask

  task automatic issue_pulse(input int dly, input int len, input logic dat);
    int t, len_eff;
    bit ok;
    ok = 1'b0; t = 0;
    pulse_delay = 16'(dly); pulse_length = 16'(len); pulse_data = dat; pulse_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (pulse_ready) begin ok = 1'b1; t = cyc; break; end
      @(negedge clk);
    end
    check("accept_ready", ok, 1);
    if (ok) begin
      len_eff = (len == 0) ? 1 : len;
      sb_q.push_back('{start_c: t + 1 + dly, end_c: t + dly + len_eff, data: dat});
    end
    @(negedge clk);
    pulse_valid = 1'b0;
    pulse_delay = 16'($urandom); pulse_length = 16'($urandom); pulse_data = ~dat;
    check("ready_drop", pulse_ready, 0);
    for (int i = 0; i < dly + len + 30; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    #1;
    check("env_done", sb_q.size(), 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t_rise;
    int highs, rises, oe_cnt;
    logic prev;

    // Reset values while reset is held
    tick(2);
    check("rst_e_out", e_out, 1);
    check("rst_d_out", d_out, 1);
    check("rst_e_oe", e_oe, 0);
    check("rst_d_oe", d_oe, 0);
    check("rst_ready", pulse_ready, 0);
    check("rst_configured", configured, 0);
    check("rst_error", config_error, 0);
    check("rst_word", config_word, 0);

    // Hint behaviour with E floated low
    do_reset();
    highs = 0; rises = 0; oe_cnt = 0;
    prev = d_pad;
    for (int i = 0; i < 2 * HINT_PERIOD; i++) begin
      @(negedge clk);
      if (d_oe) oe_cnt++;
      if (d_oe && d_out) highs++;
      if (d_pad && !prev) rises++;
      prev = d_pad;
    end
`ifdef TS4231_EMU_HINT_EN
    check("hint_high_cycles", highs, 2 * HINT_WIDTH);
    check("hint_rises", rises, 2);
    check("hint_oe_cycles", oe_cnt, 2 * HINT_PERIOD);
`else
    check("nohint_oe_cycles", oe_cnt, 0);
`endif
    check("hint_configured", configured, 0);

    // Full configuration with the expected word
    send_config(16'h7256, 16, 1'b1, t_rise);
    check_release(t_rise, 16'h7256, 1'b0);
    tick(2);
    check("idle_e_pad", e_pad, 1);
    check("idle_d_pad", d_pad, 1);
    check("idle_oe", {e_oe, d_oe}, 2'b11);

    // Envelopes
    issue_pulse(10, 300, 1'b0);
    issue_pulse(0, 0, 1'b1);
    issue_pulse(3, 1, 1'b1);
    issue_pulse(0, 7, 1'b0);

    // Reset asserted in the middle of an envelope
    pulse_delay = 16'd5; pulse_length = 16'd200; pulse_data = 1'b1; pulse_valid = 1'b1;
    for (int i = 0; i < 50 && !pulse_ready; i++) @(negedge clk);
    check("mid_accept_ready", pulse_ready, 1);
    sb_q.push_back('{start_c: cyc + 6, end_c: cyc + 205, data: 1'b1});
    @(negedge clk);
    pulse_valid = 1'b0;
    tick(50);
    check("mid_env_active", e_out, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_e_oe", e_oe, 0);
    check("mid_rst_d_oe", d_oe, 0);
    check("mid_rst_e_out", e_out, 1);
    check("mid_rst_d_out", d_out, 1);
    check("mid_rst_ready", pulse_ready, 0);
    check("mid_rst_configured", configured, 0);
    check("mid_rst_error", config_error, 0);
    check("mid_rst_word", config_word, 0);
    tick(2);
    check("mid_rst_sb_flushed", sb_q.size(), 0);

    // Stop after 15 bits, then a correct sequence
    do_reset();
    send_config(16'h7256 >> 1, 15, 1'b1, t_rise);
    tick(10);
    check("short_error", config_error, 1);
    check("short_configured", configured, 0);
    check("short_word_kept", config_word, 0);
    send_config(16'h7256, 16, 1'b1, t_rise);
    check_release(t_rise, 16'h7256, 1'b1);

    // Unexpected word still configures
    do_reset();
    send_config(16'h1234, 16, 1'b1, t_rise);
    check_release(t_rise, 16'h1234, 1'b1);

    // Stall in CFG_SHIFT, then recover from SLEEP
    do_reset();
    send_config(16'h000A, 4, 1'b0, t_rise);
    tick(EDGE_TIMEOUT - 100);
    check("stall_before_timeout", config_error, 0);
    tick(5000 - (EDGE_TIMEOUT - 100));
    check("stall_error", config_error, 1);
    check("stall_configured", configured, 0);
    send_config(16'h7256, 16, 1'b1, t_rise);
    check_release(t_rise, 16'h7256, 1'b1);

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
